// File: rtl/div_pkg.sv
// Shared constants and state type for the 12/6 sequential divider.
package div_pkg;
  localparam int unsigned DW = 12;
  localparam int unsigned VW = 6;
  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/seq_div_12by6_if.sv
// Operand/result handshake bundle for the 12/6 divider.
interface seq_div_12by6_if;
  import div_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [VW-1:0] rem,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          q_bit
);
  logic [VW:0] p;

  // Widened partial remainder so the compare cannot overflow.
  always_comb begin
    p        = {rem, bit_in};
    q_bit    = (p >= {1'b0, divisor});
    rem_next = q_bit ? VW'(p - {1'b0, divisor}) : p[VW-1:0];
  end
endmodule

// File: rtl/seq_div_12by6.sv
// Iterative restoring divider, 12-bit dividend by 6-bit divisor, one op in flight.
module seq_div_12by6
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  seq_div_12by6_if.slave   bus
);
  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dsr_q, dsr_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [DW-1:0] qsr_q, qsr_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          div_zero_q, div_zero_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic [VW-1:0] rem_next;
  logic          q_bit;

  div_step u_step (
    .rem      (rem_q),
    .bit_in   (dvd_q[DW-1]),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Next-state and next-output computation; result registers change only on DONE entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    qsr_d       = qsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d      = bus.dividend;
          dsr_d      = bus.divisor;
          rem_d      = '0;
          qsr_d      = '0;
          in_ready_d = 1'b0;
          if (bus.divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            div_zero_d  = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(DW - 1);
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        rem_d = rem_next;
        qsr_d = {qsr_q[DW-2:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = {qsr_q[DW-2:0], q_bit};
          remainder_d = rem_next;
          div_zero_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      qsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      qsr_q       <= qsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_seq_div_12by6.sv
// Bench for seq_div_12by6: directed cases, hold/reset cases, random back-to-back stream.
module tb_seq_div_12by6;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_div_12by6_if bus();

  seq_div_12by6 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned acc;
  } op_t;

  op_t pend[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_q(input int unsigned a, input int unsigned b);
    return (b == 0) ? 32'hFFF : 32'(a / b);
  endfunction

  function automatic logic [31:0] ref_r(input int unsigned a, input int unsigned b);
    return (b == 0) ? 32'd0 : 32'(a % b);
  endfunction

  // Issue one op, measure latency, check result, optionally stall the consumer, then release.
  task automatic run_op(input int unsigned a, input int unsigned b, input int unsigned hold);
    int unsigned n;
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.dividend = 12'(a);
    bus.divisor  = 6'(b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, (b == 0) ? 1 : 13);
    check("quotient", bus.quotient, ref_q(a, b));
    check("remainder", bus.remainder, ref_r(a, b));
    check("div_zero", bus.div_zero, (b == 0) ? 1 : 0);
    check("in_ready_done", bus.in_ready, 0);
    if (b != 0) check("invariant", bus.quotient * b + bus.remainder, a);
    for (int i = 0; i < int'(hold); i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = 12'd1;
      bus.divisor  = 6'd1;
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_quotient", bus.quotient, ref_q(a, b));
      check("hold_remainder", bus.remainder, ref_r(a, b));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
    check("release_quotient_held", bus.quotient, ref_q(a, b));
    if (hold > 0) begin
      @(negedge clk);
      check("hold_input_ignored", bus.in_ready, 1);
    end
  endtask

  initial begin
    int unsigned got, pushed, hs, a, b, lat;
    op_t o;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_div_zero", bus.div_zero, 0);
    rst = 1'b0;

    run_op(2205, 63, 0);
    run_op(100, 7, 0);
    run_op(4095, 1, 0);
    run_op(0, 5, 0);
    run_op(500, 0, 0);
    run_op(4095, 63, 5);

    // Reset in the middle of a calculation.
    @(negedge clk);
    bus.dividend = 12'd3000;
    bus.divisor  = 6'd37;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_quotient", bus.quotient, 0);
    check("midrst_remainder", bus.remainder, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    run_op(3000, 37, 0);

    // Random back-to-back stream with the producer always offering and consumer always ready.
    got = 0;
    pushed = 0;
    hs = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 300 * 14 + 200 && got < 300; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (pend.size() == 0) begin
          check("rand_spurious_valid", 1, 0);
        end else begin
          o = pend.pop_front();
          lat = cyc - o.acc + 1;
          check("rand_latency", lat, (o.b == 0) ? 1 : 13);
          check("rand_quotient", bus.quotient, ref_q(o.a, o.b));
          check("rand_remainder", bus.remainder, ref_r(o.a, o.b));
          check("rand_div_zero", bus.div_zero, (o.b == 0) ? 1 : 0);
          if (o.b != 0) check("rand_invariant", bus.quotient * o.b + bus.remainder, o.a);
          hs = cyc + 1;
          got++;
        end
      end
      if (bus.in_ready) begin
        if (pushed < 300) begin
          a = $urandom_range(0, 4095);
          b = $urandom_range(0, 63);
          bus.dividend = 12'(a);
          bus.divisor  = 6'(b);
          bus.in_valid = 1'b1;
          if (got > 0) check("rand_accept_gap", (cyc + 1) - hs, 1);
          pend.push_back('{a: a, b: b, acc: cyc + 1});
          pushed++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_results", got, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
